// File: rtl/apb_pwm_arbiter.sv
// Two-port APB arbiter in front of a single PWM slave.
// Round-robin on ties, replays the winner as SETUP/ACCESS, with access timeout.
module apb_pwm_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK_i,
  input  logic                  PRST_ni,
  input  logic                  S0_PSEL_i,
  input  logic                  S0_PENABLE_i,
  input  logic                  S0_PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] S0_PADDR_i,
  input  logic [DATA_WIDTH-1:0] S0_PWDATA_i,
  output logic [DATA_WIDTH-1:0] S0_PRDATA_o,
  output logic                  S0_PREADY_o,
  output logic                  S0_PSLVERR_o,
  input  logic                  S1_PSEL_i,
  input  logic                  S1_PENABLE_i,
  input  logic                  S1_PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] S1_PADDR_i,
  input  logic [DATA_WIDTH-1:0] S1_PWDATA_i,
  output logic [DATA_WIDTH-1:0] S1_PRDATA_o,
  output logic                  S1_PREADY_o,
  output logic                  S1_PSLVERR_o,
  output logic                  M_PSEL_o,
  output logic                  M_PENABLE_o,
  output logic                  M_PWRITE_o,
  output logic [ADDR_WIDTH-1:0] M_PADDR_o,
  output logic [DATA_WIDTH-1:0] M_PWDATA_o,
  input  logic [DATA_WIDTH-1:0] M_PRDATA_i,
  input  logic                  M_PREADY_i,
  input  logic                  M_PSLVERR_i,
  output logic [1:0]            grant_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;

  logic pick1;
  logic unused_penable;

  // Requests are PSEL alone; PENABLE carries no extra information here.
  assign unused_penable = S0_PENABLE_i ^ S1_PENABLE_i;

  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign pick1 = S1_PSEL_i & (~S0_PSEL_i | ~last_q);

  // State and transfer registers.
  always_ff @(posedge PCLK_i or negedge PRST_ni) begin
    if (!PRST_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait/timeout in ACCESS, complete in DONE.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    cnt_d    = '0;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (S0_PSEL_i || S1_PSEL_i) begin
          state_d = SETUP;
          if (pick1) begin
            grant_d = 2'b10;
            addr_d  = S1_PADDR_i;
            wdata_d = S1_PWDATA_i;
            write_d = S1_PWRITE_i;
          end else begin
            grant_d = 2'b01;
            addr_d  = S0_PADDR_i;
            wdata_d = S0_PWDATA_i;
            write_d = S0_PWRITE_i;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (M_PREADY_i) begin
          state_d  = DONE;
          rdata_d  = write_q ? '0 : M_PRDATA_i;
          slverr_d = M_PSLVERR_i;
          last_d   = grant_q[1];
        end else if (cnt_q == LIMIT) begin
          state_d  = DONE;
          rdata_d  = '0;
          slverr_d = 1'b1;
          last_d   = grant_q[1];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; all zero whenever not actively driven.
  always_comb begin
    M_PSEL_o     = 1'b0;
    M_PENABLE_o  = 1'b0;
    M_PWRITE_o   = 1'b0;
    M_PADDR_o    = '0;
    M_PWDATA_o   = '0;
    grant_o      = '0;
    S0_PREADY_o  = 1'b0;
    S0_PRDATA_o  = '0;
    S0_PSLVERR_o = 1'b0;
    S1_PREADY_o  = 1'b0;
    S1_PRDATA_o  = '0;
    S1_PSLVERR_o = 1'b0;
    if (state_q != IDLE) begin
      grant_o = grant_q;
    end
    if (state_q == SETUP || state_q == ACCESS) begin
      M_PSEL_o    = 1'b1;
      M_PENABLE_o = (state_q == ACCESS);
      M_PWRITE_o  = write_q;
      M_PADDR_o   = addr_q;
      M_PWDATA_o  = wdata_q;
    end
    if (state_q == DONE) begin
      if (grant_q[0]) begin
        S0_PREADY_o  = 1'b1;
        S0_PRDATA_o  = rdata_q;
        S0_PSLVERR_o = slverr_q;
      end
      if (grant_q[1]) begin
        S1_PREADY_o  = 1'b1;
        S1_PRDATA_o  = rdata_q;
        S1_PSLVERR_o = slverr_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_pwm_arbiter.sv
// Directed bench for apb_pwm_arbiter.
// Vector table of single transfers plus contention and reset sequences.
module tb_apb_pwm_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s0_sel = 0, s0_en = 0, s0_wr = 0;
  logic [AW-1:0] s0_addr = '0;
  logic [DW-1:0] s0_wdata = '0;
  logic [DW-1:0] s0_rdata;
  logic          s0_rdy, s0_err;
  logic          s1_sel = 0, s1_en = 0, s1_wr = 0;
  logic [AW-1:0] s1_addr = '0;
  logic [DW-1:0] s1_wdata = '0;
  logic [DW-1:0] s1_rdata;
  logic          s1_rdy, s1_err;
  logic          m_sel, m_en, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_rdy = 0, m_err = 0;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  apb_pwm_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT(TO)
  ) dut (
    .PCLK_i(clk),
    .PRST_ni(rst_n),
    .S0_PSEL_i(s0_sel),
    .S0_PENABLE_i(s0_en),
    .S0_PWRITE_i(s0_wr),
    .S0_PADDR_i(s0_addr),
    .S0_PWDATA_i(s0_wdata),
    .S0_PRDATA_o(s0_rdata),
    .S0_PREADY_o(s0_rdy),
    .S0_PSLVERR_o(s0_err),
    .S1_PSEL_i(s1_sel),
    .S1_PENABLE_i(s1_en),
    .S1_PWRITE_i(s1_wr),
    .S1_PADDR_i(s1_addr),
    .S1_PWDATA_i(s1_wdata),
    .S1_PRDATA_o(s1_rdata),
    .S1_PREADY_o(s1_rdy),
    .S1_PSLVERR_o(s1_err),
    .M_PSEL_o(m_sel),
    .M_PENABLE_o(m_en),
    .M_PWRITE_o(m_wr),
    .M_PADDR_o(m_addr),
    .M_PWDATA_o(m_wdata),
    .M_PRDATA_i(m_rdata),
    .M_PREADY_i(m_rdy),
    .M_PSLVERR_i(m_err),
    .grant_o(grant)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input bit p, input logic sel, input logic en,
                     input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    if (p == 1'b0) begin
      s0_sel = sel; s0_en = en; s0_wr = wr; s0_addr = a; s0_wdata = d;
    end else begin
      s1_sel = sel; s1_en = en; s1_wr = wr; s1_addr = a; s1_wdata = d;
    end
  endtask

  typedef struct {
    bit            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    int            waits;
    bit            slverr;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    int            exp_lat;
    int            exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int cyc;
    int acc;
    bit done;
    bit other_bad;
    logic          own_rdy, oth_rdy, oth_err, own_err;
    logic [DW-1:0] own_rd, oth_rd;
    @(posedge clk); #1;
    drv(v.port, 1, 0, v.wr, v.addr, v.wdata);
    m_rdata = v.prdata;
    m_rdy = 0;
    m_err = 0;
    @(negedge clk);
    chk("idle_msel", m_sel, 0);
    cyc = 0; acc = 0; done = 0; other_bad = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      drv(v.port, 1, 1, v.wr, v.addr, v.wdata);
      m_rdy = 0;
      m_err = 0;
      if (cyc == 1) begin
        chk("setup_sel_en", {30'd0, m_sel, m_en}, 32'h2);
      end
      if (m_sel && m_en) begin
        if (acc == 0) begin
          chk("acc_addr", m_addr, v.addr);
          chk("acc_wdata", m_wdata, v.wdata);
          chk("acc_write", m_wr, v.wr);
        end
        if (acc == v.waits) begin
          m_rdy = 1;
          m_err = v.slverr;
        end
        acc++;
      end
      @(negedge clk);
      own_rdy = v.port ? s1_rdy : s0_rdy;
      own_rd  = v.port ? s1_rdata : s0_rdata;
      own_err = v.port ? s1_err : s0_err;
      oth_rdy = v.port ? s0_rdy : s1_rdy;
      oth_rd  = v.port ? s0_rdata : s1_rdata;
      oth_err = v.port ? s0_err : s1_err;
      if (oth_rdy || oth_err || oth_rd != 0) other_bad = 1;
      if (own_rdy) begin
        done = 1;
        chk("latency", cyc, v.exp_lat);
        chk("access_cycles", acc, v.exp_acc);
        chk("rdata", own_rd, v.exp_rdata);
        chk("slverr", own_err, v.exp_err);
        chk("grant", grant, v.port ? 2 : 1);
        chk("done_msel", m_sel, 0);
      end
    end
    chk("done_seen", done, 1);
    chk("other_quiet", other_bad, 0);
    @(posedge clk); #1;
    drv(v.port, 0, 0, 0, '0, '0);
    m_rdy = 0;
    @(negedge clk);
    own_rdy = v.port ? s1_rdy : s0_rdy;
    own_rd  = v.port ? s1_rdata : s0_rdata;
    chk("after_rdy", own_rdy, 0);
    chk("after_rdata", own_rd, 0);
    chk("after_grant", grant, 0);
    chk("after_maddr", m_addr, 0);
  endtask

  task automatic contention();
    int rem[2];
    bit fin[2];
    logic [DW-1:0] dlog[$];
    logic [1:0]    glog[$];
    bit both;
    logic [DW-1:0] exp_d[4];
    logic [1:0]    exp_g[4];
    exp_d = '{32'h00, 32'h10, 32'h01, 32'h11};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    rem = '{2, 2};
    fin = '{0, 0};
    both = 0;
    m_rdy = 1;
    m_err = 0;
    m_rdata = 32'hCAFE;
    @(posedge clk); #1;
    drv(0, 1, 0, 1, 8'h20, 32'h00);
    drv(1, 1, 0, 1, 8'h21, 32'h10);
    for (int c = 0; c < 60 && (rem[0] > 0 || rem[1] > 0); c++) begin
      @(negedge clk);
      if (m_en && m_rdy) dlog.push_back(m_wdata);
      if (s0_rdy && s1_rdy) both = 1;
      if (s0_rdy) begin glog.push_back(grant); fin[0] = 1; end
      if (s1_rdy) begin glog.push_back(grant); fin[1] = 1; end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (fin[p]) begin
          fin[p] = 0;
          rem[p]--;
          if (rem[p] > 0)
            drv(p[0], 1, 0, 1, 8'(32 + p), 32'(p * 16 + 2 - rem[p]));
          else
            drv(p[0], 0, 0, 0, '0, '0);
        end else if (p == 0 ? s0_sel : s1_sel) begin
          if (p == 0) s0_en = 1; else s1_en = 1;
        end
      end
    end
    m_rdy = 0;
    chk("cont_count", dlog.size(), 4);
    chk("cont_gcount", glog.size(), 4);
    chk("cont_both_ready", both, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < dlog.size()) chk($sformatf("cont_data%0d", i), dlog[i], exp_d[i]);
      if (i < glog.size()) chk($sformatf("cont_grant%0d", i), glog[i], exp_g[i]);
    end
  endtask

  initial begin
    vecs[0] = '{0, 1, 8'h04, 32'h0000_00FF, 32'h0, 0, 0, 32'h0, 0, 3, 1};
    vecs[1] = '{1, 0, 8'h08, 32'h0, 32'h1234_5678, 0, 0, 32'h1234_5678, 0, 3, 1};
    vecs[2] = '{0, 0, 8'h10, 32'h0, 32'hDEAD_BEEF, 3, 1, 32'hDEAD_BEEF, 1, 6, 4};
    vecs[3] = '{1, 1, 8'h14, 32'h55AA, 32'h7777, 3, 1, 32'h0, 1, 6, 4};
    vecs[4] = '{0, 0, 8'h18, 32'h0, 32'hBBBB, 99, 0, 32'h0, 1, 18, 16};
    vecs[5] = '{1, 0, 8'h1C, 32'h0, 32'hA5A5, 15, 0, 32'hA5A5, 0, 18, 16};
    vecs[6] = '{0, 1, 8'h30, 32'h1357, 32'h0, 1, 0, 32'h0, 0, 4, 2};

    #12;
    chk("rst_msel", m_sel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_s0rdy", s0_rdy, 0);
    chk("rst_s1rdy", s1_rdy, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    @(posedge clk); #1;
    drv(0, 1, 0, 0, 8'h40, '0);
    m_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_access", {30'd0, m_sel, m_en}, 32'h3);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_msel", m_sel, 0);
    chk("mid_rst_men", m_en, 0);
    chk("mid_rst_grant", grant, 0);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    rst_n = 1;

    contention();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
